// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage pipeline; one imem request in flight.
// Ports:
//   clk, resetn (async, active-low)
//   IF_valid, next_fetch          : pipeline controller enable / advance
//   cancel, redirect_pc           : flush and restart at redirect_pc
//   jbr_taken, jbr_target         : taken branch/jump from ID
//   inst_req/addr/gnt/rvalid/rdata: instruction-memory handshake
//   IF_over, IF_inst, IF_pc, IF_adel: fetched word presented to ID
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic        cancel,
    input  logic [31:0] redirect_pc,
    input  logic        jbr_taken,
    input  logic [31:0] jbr_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic        IF_over,
    output logic [31:0] IF_inst,
    output logic [31:0] IF_pc,
    output logic        IF_adel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic [31:0] pc_nx;
    logic        discard;
    logic        discard_nx;
    logic        cap_ok;
    logic        cap_adel;
    logic        misal;

    assign misal     = |pc[1:0];
    assign inst_addr = pc;
    assign IF_over   = (state == S_HOLD);

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        discard_nx = discard;
        cap_ok     = 1'b0;
        cap_adel   = 1'b0;
        inst_req   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cancel)
                    pc_nx = redirect_pc;
                else if (IF_valid)
                    state_nx = S_REQ;
            end
            S_REQ: begin
                // a misaligned pc never reaches memory
                inst_req = !misal;
                if (cancel) begin
                    pc_nx = redirect_pc;
                    // request already accepted: its data must be dropped
                    if (!misal && inst_gnt) begin
                        state_nx   = S_WAIT;
                        discard_nx = 1'b1;
                    end
                end else if (misal) begin
                    state_nx = S_HOLD;
                    cap_adel = 1'b1;
                end else if (inst_gnt) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cancel)
                    pc_nx = redirect_pc;
                if (inst_rvalid) begin
                    if (discard || cancel) begin
                        discard_nx = 1'b0;
                        state_nx   = S_REQ;
                    end else begin
                        cap_ok   = 1'b1;
                        state_nx = S_HOLD;
                    end
                end else if (cancel) begin
                    discard_nx = 1'b1;
                end
            end
            S_HOLD: begin
                if (cancel) begin
                    pc_nx    = redirect_pc;
                    state_nx = S_REQ;
                end else if (next_fetch) begin
                    pc_nx    = jbr_taken ? jbr_target : pc + 32'd4;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            discard <= 1'b0;
            IF_inst <= 32'h0;
            IF_pc   <= 32'h0;
            IF_adel <= 1'b0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            discard <= discard_nx;
            if (cap_ok) begin
                IF_inst <= inst_rdata;
                IF_pc   <= pc;
                IF_adel <= 1'b0;
            end else if (cap_adel) begin
                IF_inst <= 32'h0;
                IF_pc   <= pc;
                IF_adel <= 1'b1;
            end
        end
    end

endmodule
